msg_transmit_drv: RTL and testbench
===================================

// Module: msg_transmit_drv
// PURPOSE
//  Per-sensor-channel frame builder in the message transmit path. On a start request it
//  emits one 128-bit header word, then drains a fixed number of bytes from that channel's
//  8-bit FIFO and packs them into 128-bit payload words.
//  It pulses send_done_o when the frame is complete. The upper wrapper instantiates one
//  per channel, starts them one at a time, and muxes flow_* into the upstream FIFO.
// PARAMETERS
//  ILA_CH  0  channel index used as a debug tag only; no functional effect
// PORTS
//  sys_clk_i               in   1    clock
//  rst_n_i                 in   1    asynchronous, active-low reset
//  transmit_start_pluse_i  in   1    start request (level, held until send_done_o)
//  send_done_o             out  1    1-cycle pulse, frame finished
//  transmit_header         in   32   frame sync word (normally 32'hFDF7_EB90)
//  transmit_frame_type     in   4    frame type
//  transmit_frame_cnt      in   16   frame sequence number
//  transmit_src_id         in   8    source id
//  transmit_des_id         in   8    destination id
//  transmit_data_type      in   8    data type
//  transmit_data_channel   in   8    data channel
//  rd_clk_o                out  1    FIFO read clock, = sys_clk_i
//  rd_en_o                 out  1    FIFO read enable (standard, non-FWFT FIFO)
//  din_i                   in   8    FIFO read data, valid 1 cycle after rd_en_o
//  data_count_i            in   16   bytes to send in this frame
//  empty_i                 in   1    FIFO empty
//  flow_valid_o            out  1    output word strobe
//  flow_data_o             out  128  output word
// BEHAVIOUR
//  - Reset: state IDLE; rd_en_o, flow_valid_o and send_done_o = 0; flow_data_o = 0;
//    start-edge register = 0.
//  - Start:
//    - Start = rising edge of transmit_start_pluse_i, taken only in IDLE.
//    - A level still high after done does not retrigger.
//    - On start, latch data_count_i and all header fields.
//  - Header word is valid the cycle after the start edge is detected:
//    - [127:96] header, [95:92] type, [91:88] 0, [87:72] frame_cnt
//    - [71:64] src, [63:56] des, [55:48] data_type, [47:40] channel
//    - [39:24] byte length, [23:0] 0
//  - States:
//    - IDLE -> HEAD on start.
//    - HEAD -> READ if length != 0, else DONE.
//    - READ -> LAST when the final byte is captured.
//    - LAST -> DONE.
//    - DONE -> IDLE.
//  - READ:
//    - rd_en_o = !empty_i && bytes_requested < length; never over-read.
//    - Each byte captured 1 cycle after its rd_en_o.
//    - Bytes are packed MSB first: first byte goes to [127:120].
//    - flow_valid_o pulses 1 cycle with the word each time 16 bytes are packed.
//    - If empty_i stays high mid-frame: stall indefinitely, no timeout.
//  - LAST:
//    - If a partial word remains, emit it with the unused low bytes zero.
//    - Length that is a multiple of 16: no extra word.
//  - DONE: send_done_o = 1 for exactly one cycle, then IDLE.
//  - Backpressure: none; flow_valid_o is never throttled.
//  - Counters: 16-bit byte counter, 4-bit byte lane; length 0..65535 supported.
//  - Reset mid-frame: aborts immediately to the reset values; no done pulse.
//  - flow_data_o holds its last value when flow_valid_o = 0.
// STRUCTURE
//  - Shared package msg_pkg:
//    - state enum IDLE/HEAD/READ/LAST/DONE
//    - header default 32'hFDF7_EB90
//    - header field bit-offset constants
//  - One natural sub-module: byte_packer_128.
//    - Input: 8-bit byte + valid, plus flush.
//    - Output: 128-bit word + valid, zero-padded on flush.
//  - ila_msg_trans is a vendor debug core; it is instantiated in the wrapper only, not here.
// TESTING
//  - len=0, start rises:
//    - one header word with [39:24]=0;
//    - send_done_o pulses 1 cycle later;
//    - rd_en_o never asserted.
//  - len=16, FIFO bytes 0x00..0x0F:
//    - header, then 128'h000102..0F;
//    - exactly 16 rd_en_o cycles;
//    - one send_done_o pulse.
//  - len=20, bytes 0xA0..0xB3:
//    - header, then a full word;
//    - last word 128'hB0B1B2B3 followed by 96 zero bits;
//    - then done.
//  - len=5, empty_i high for 10 cycles after byte 2:
//    - rd_en_o low while empty, resumes afterwards;
//    - word 0x0102030405 followed by zeros.
//  - Start held high for 100 cycles after done:
//    - no second frame.
//    - A low->high transition then starts a new frame with the new frame_cnt.
//  - rst_n_i low in the middle of READ:
//    - all outputs 0 immediately;
//    - after release, stays IDLE until the next start edge.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types and constants for the message transmit path.
package msg_pkg;

  // Frame builder sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_READ = 3'd2,
    ST_LAST = 3'd3,
    ST_DONE = 3'd4
  } msg_state_e;

  // Frame sync word normally driven onto transmit_header.
  localparam logic [31:0] MSG_HEADER_DEFAULT = 32'hFDF7_EB90;

  // LSB positions of each field inside the 128-bit header word.
  localparam int HDR_SYNC_LSB  = 96;
  localparam int HDR_TYPE_LSB  = 92;
  localparam int HDR_CNT_LSB   = 72;
  localparam int HDR_SRC_LSB   = 64;
  localparam int HDR_DES_LSB   = 56;
  localparam int HDR_DTYPE_LSB = 48;
  localparam int HDR_CHAN_LSB  = 40;
  localparam int HDR_LEN_LSB   = 24;

  // Header fields as latched at frame start.
  typedef struct packed {
    logic [31:0] sync;
    logic [3:0]  frame_type;
    logic [15:0] frame_cnt;
    logic [7:0]  src_id;
    logic [7:0]  des_id;
    logic [7:0]  data_type;
    logic [7:0]  data_channel;
    logic [15:0] byte_len;
  } msg_hdr_t;

  // Places each field at its offset; reserved bits stay zero.
  function automatic logic [127:0] build_header(input msg_hdr_t h);
    logic [127:0] word;
    word = '0;
    word[HDR_SYNC_LSB  +: 32] = h.sync;
    word[HDR_TYPE_LSB  +: 4]  = h.frame_type;
    word[HDR_CNT_LSB   +: 16] = h.frame_cnt;
    word[HDR_SRC_LSB   +: 8]  = h.src_id;
    word[HDR_DES_LSB   +: 8]  = h.des_id;
    word[HDR_DTYPE_LSB +: 8]  = h.data_type;
    word[HDR_CHAN_LSB  +: 8]  = h.data_channel;
    word[HDR_LEN_LSB   +: 16] = h.byte_len;
    return word;
  endfunction

endpackage

// File: rtl/msg_transmit_drv_byte_packer.sv
// Packs a byte stream MSB-first into 128-bit words; flush emits a zero-padded partial word.
module byte_packer_128 (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  input  logic         i_clr,
  input  logic         i_byte_valid,
  input  logic [7:0]   i_byte,
  input  logic         i_flush,
  output logic [127:0] o_word,
  output logic         o_word_valid
);

  logic [127:0] r_acc;
  logic [3:0]   r_lane;
  logic [127:0] r_word;
  logic         r_word_valid;
  logic [127:0] w_acc_ins;
  logic [6:0]   w_lsb;

  // Lane 0 lands in [127:120], lane 15 in [7:0]; ~lane equals 15-lane.
  always_comb begin
    w_lsb     = {~r_lane, 3'b000};
    w_acc_ins = r_acc;
    w_acc_ins[w_lsb +: 8] = i_byte;
  end

  // Accumulate bytes; a full word or a flush with pending bytes produces one output pulse.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc        <= '0;
      r_lane       <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clr) begin
        r_acc  <= '0;
        r_lane <= '0;
      end else if (i_byte_valid) begin
        if (r_lane == 4'hF) begin
          r_word       <= w_acc_ins;
          r_word_valid <= 1'b1;
          r_acc        <= '0;
          r_lane       <= '0;
        end else begin
          r_acc  <= w_acc_ins;
          r_lane <= r_lane + 4'd1;
        end
      end else if (i_flush) begin
        if (r_lane != 4'd0) begin
          r_word       <= r_acc;
          r_word_valid <= 1'b1;
        end
        r_acc  <= '0;
        r_lane <= '0;
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/msg_transmit_drv.sv
// Per-channel frame builder: header word, then FIFO bytes packed into 128-bit payload words.
module msg_transmit_drv
  import msg_pkg::*;
#(
  parameter int ILA_CH = 0
) (
  input  logic         sys_clk_i,
  input  logic         rst_n_i,
  input  logic         transmit_start_pluse_i,
  output logic         send_done_o,
  input  logic [31:0]  transmit_header,
  input  logic [3:0]   transmit_frame_type,
  input  logic [15:0]  transmit_frame_cnt,
  input  logic [7:0]   transmit_src_id,
  input  logic [7:0]   transmit_des_id,
  input  logic [7:0]   transmit_data_type,
  input  logic [7:0]   transmit_data_channel,
  output logic         rd_clk_o,
  output logic         rd_en_o,
  input  logic [7:0]   din_i,
  input  logic [15:0]  data_count_i,
  input  logic         empty_i,
  output logic         flow_valid_o,
  output logic [127:0] flow_data_o
);

  // Channel index is only a debug tag; a negative value is meaningless.
  if (ILA_CH < 0) begin : g_ila_ch_negative
  end

  msg_state_e   r_state;
  msg_state_e   w_state_next;
  logic         r_start_d;
  logic         w_start_edge;
  msg_hdr_t     w_hdr_fields;
  logic [127:0] r_hdr_word;
  logic         r_hdr_valid;
  logic [15:0]  r_len;
  logic [15:0]  r_req_cnt;
  logic [15:0]  r_cap_cnt;
  logic         r_rd_en_d;
  logic         w_cap;
  logic         w_last_byte;
  logic         w_rd_en;
  logic         w_flush;
  logic         w_done;
  logic [127:0] w_pack_word;
  logic         w_pack_valid;
  logic [127:0] r_flow_hold;
  logic         w_flow_valid;
  logic [127:0] w_flow_data;

  assign rd_clk_o = sys_clk_i;

  // Start is a rising edge of the request level, accepted only while idle.
  assign w_start_edge = transmit_start_pluse_i & ~r_start_d & (r_state == ST_IDLE);
  // A byte requested last cycle is on din_i now (standard-mode FIFO).
  assign w_cap        = r_rd_en_d;
  assign w_last_byte  = w_cap && (r_cap_cnt == r_len - 16'd1);

  // Header fields sampled at the moment of the start edge.
  always_comb begin
    w_hdr_fields              = '0;
    w_hdr_fields.sync         = transmit_header;
    w_hdr_fields.frame_type   = transmit_frame_type;
    w_hdr_fields.frame_cnt    = transmit_frame_cnt;
    w_hdr_fields.src_id       = transmit_src_id;
    w_hdr_fields.des_id       = transmit_des_id;
    w_hdr_fields.data_type    = transmit_data_type;
    w_hdr_fields.data_channel = transmit_data_channel;
    w_hdr_fields.byte_len     = data_count_i;
  end

  // State register.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_flush      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_edge) w_state_next = ST_HEAD;
      ST_HEAD: w_state_next = (r_len != 16'd0) ? ST_READ : ST_DONE;
      ST_READ: begin
        // Stall indefinitely on empty; stop requesting once length is reached.
        w_rd_en = !empty_i && (r_req_cnt < r_len);
        if (w_last_byte) w_state_next = ST_LAST;
      end
      ST_LAST: begin
        w_flush      = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Track the request level so a held-high start does not retrigger.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_start_d <= 1'b0;
    else          r_start_d <= transmit_start_pluse_i;
  end

  // Latch the header word and length at start; header strobes in the following cycle.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hdr_word  <= '0;
      r_hdr_valid <= 1'b0;
      r_len       <= '0;
    end else begin
      r_hdr_valid <= w_start_edge;
      if (w_start_edge) begin
        r_hdr_word <= build_header(w_hdr_fields);
        r_len      <= data_count_i;
      end
    end
  end

  // Bytes requested / captured this frame, plus the one-cycle read-data delay.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_req_cnt <= '0;
      r_cap_cnt <= '0;
      r_rd_en_d <= 1'b0;
    end else begin
      r_rd_en_d <= w_rd_en;
      if (w_start_edge) begin
        r_req_cnt <= '0;
        r_cap_cnt <= '0;
      end else begin
        if (w_rd_en) r_req_cnt <= r_req_cnt + 16'd1;
        if (w_cap)   r_cap_cnt <= r_cap_cnt + 16'd1;
      end
    end
  end

  byte_packer_128 u_packer (
    .sys_clk_i    (sys_clk_i),
    .rst_n_i      (rst_n_i),
    .i_clr        (w_start_edge),
    .i_byte_valid (w_cap),
    .i_byte       (din_i),
    .i_flush      (w_flush),
    .o_word       (w_pack_word),
    .o_word_valid (w_pack_valid)
  );

  // Header and payload never strobe in the same cycle; between strobes the last word is held.
  assign w_flow_valid = r_hdr_valid | w_pack_valid;
  assign w_flow_data  = r_hdr_valid  ? r_hdr_word  :
                        w_pack_valid ? w_pack_word : r_flow_hold;

  // Remember the last word put on the bus.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)          r_flow_hold <= '0;
    else if (w_flow_valid) r_flow_hold <= w_flow_data;
  end

  assign flow_valid_o = w_flow_valid;
  assign flow_data_o  = w_flow_data;
  assign rd_en_o      = w_rd_en;
  assign send_done_o  = w_done;

endmodule

// File: tb/tb_msg_transmit_drv.sv
// Scoreboard bench for msg_transmit_drv with a standard-mode byte FIFO model.
module tb_msg_transmit_drv;
  import msg_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         send_done_o;
  logic [31:0]  hdr_sync = MSG_HEADER_DEFAULT;
  logic [3:0]   frame_type = 4'h5;
  logic [15:0]  frame_cnt = 16'h0;
  logic [7:0]   src_id = 8'h11;
  logic [7:0]   des_id = 8'h22;
  logic [7:0]   data_type = 8'h33;
  logic [7:0]   data_chan = 8'h44;
  logic         rd_clk_o;
  logic         rd_en_o;
  logic [7:0]   din_i = 8'h00;
  logic [15:0]  data_count = 16'h0;
  logic         empty_i = 1'b1;
  logic         flow_valid_o;
  logic [127:0] flow_data_o;

  int vectors = 0;
  int miscompares = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int flow_cnt = 0;

  logic [127:0] sb[$];
  logic [7:0]   fifo[$];
  logic         rd_take = 1'b0;
  logic [7:0]   rd_byte = 8'h00;

  always #5 clk = ~clk;

  msg_transmit_drv #(.ILA_CH(0)) dut (
    .sys_clk_i              (clk),
    .rst_n_i                (rst_n),
    .transmit_start_pluse_i (start),
    .send_done_o            (send_done_o),
    .transmit_header        (hdr_sync),
    .transmit_frame_type    (frame_type),
    .transmit_frame_cnt     (frame_cnt),
    .transmit_src_id        (src_id),
    .transmit_des_id        (des_id),
    .transmit_data_type     (data_type),
    .transmit_data_channel  (data_chan),
    .rd_clk_o               (rd_clk_o),
    .rd_en_o                (rd_en_o),
    .din_i                  (din_i),
    .data_count_i           (data_count),
    .empty_i                (empty_i),
    .flow_valid_o           (flow_valid_o),
    .flow_data_o            (flow_data_o)
  );

  // Monitor: samples mid-cycle, pops the FIFO on read requests, checks words against the scoreboard.
  always @(negedge clk) begin
    rd_take = 1'b0;
    if (rst_n) begin
      if (rd_en_o) begin
        rd_cnt++;
        rd_take = 1'b1;
        if (fifo.size() > 0) rd_byte = fifo.pop_front();
        else begin
          vectors++; miscompares++;
          $display("FAIL fifo_overread: rd_en_o=1 got, required 0 with FIFO empty");
        end
      end
      if (send_done_o) done_cnt++;
      if (flow_valid_o) begin
        logic [127:0] exp;
        flow_cnt++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got %h, required no word", flow_data_o);
        end else begin
          exp = sb.pop_front();
          if (flow_data_o !== exp) begin
            miscompares++;
            $display("FAIL flow_word: got %h, required %h", flow_data_o, exp);
          end else
            $display("word %0d ok %h", flow_cnt, flow_data_o);
        end
      end
    end
  end

  // FIFO read data appears the edge after rd_en; empty tracks the model contents.
  always @(posedge clk) begin
    if (rd_take) din_i <= rd_byte;
    empty_i <= (fifo.size() == 0);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    vectors++;
    if ({flow_valid_o, rd_en_o, send_done_o} !== 3'b000 || flow_data_o !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b rd=%b done=%b data=%h, required all 0",
               flow_valid_o, rd_en_o, send_done_o, flow_data_o);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    vectors++;
    if (flow_cnt != 0 || rd_cnt != 0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got words=%0d reads=%0d dones=%0d, required 0/0/0",
               flow_cnt, rd_cnt, done_cnt);
    end
  endtask

  // One frame: split bytes are queued up front, the rest after a 10-cycle empty stall.
  task automatic run_frame(input string name, input int len, input logic [7:0] base,
                           input logic [15:0] cnt, input int split, input int hold);
    logic [127:0] w;
    int lane, rd0, d0, fd, stall_rd;
    frame_cnt  = cnt;
    frame_type = cnt[3:0];
    data_count = len[15:0];
    sb.push_back({hdr_sync, frame_type, 4'h0, cnt, src_id, des_id, data_type, data_chan,
                  len[15:0], 24'h0});
    w = '0; lane = 0;
    for (int i = 0; i < len; i++) begin
      w[127 - 8*lane -: 8] = base + 8'(i);
      lane++;
      if (lane == 16) begin sb.push_back(w); w = '0; lane = 0; end
    end
    if (lane != 0) sb.push_back(w);
    for (int i = 0; i < split; i++) fifo.push_back(base + 8'(i));
    rd0 = rd_cnt; d0 = done_cnt;
    tick();
    start = 1'b1;
    if (split < len) begin
      for (int i = 0; i < 200 && fifo.size() != 0; i++) tick();
      tick();
      stall_rd = 0;
      repeat (10) begin tick(); if (rd_en_o !== 1'b0) stall_rd++; end
      vectors++;
      if (stall_rd != 0) begin
        miscompares++;
        $display("FAIL %s_stall_rd: got %0d rd_en cycles while empty, required 0", name, stall_rd);
      end
      for (int i = split; i < len; i++) fifo.push_back(base + 8'(i));
    end
    for (int i = 0; i < 2000 && done_cnt == d0; i++) tick();
    vectors++;
    if (done_cnt == d0) begin
      miscompares++;
      $display("FAIL %s_timeout: got no send_done_o, required one pulse", name);
    end
    fd = flow_cnt;
    repeat (hold) tick();
    start = 1'b0;
    repeat (3) tick();
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt - d0);
    end
    vectors++;
    if (rd_cnt - rd0 != len) begin
      miscompares++;
      $display("FAIL %s_rd_count: got %0d, required %0d", name, rd_cnt - rd0, len);
    end
    vectors++;
    if (sb.size() != 0 || flow_cnt != fd) begin
      miscompares++;
      $display("FAIL %s_words: got %0d missing, %0d after done, required 0/0",
               name, sb.size(), flow_cnt - fd);
    end
  endtask

  task automatic test_zero_len();    run_frame("len0",  0,  8'h00, 16'h0001, 0, 0); endtask
  task automatic test_full_word();   run_frame("len16", 16, 8'h00, 16'h0002, 16, 0); endtask
  task automatic test_partial();     run_frame("len20", 20, 8'hA0, 16'h0003, 20, 0); endtask
  task automatic test_empty_stall(); run_frame("stall", 5,  8'h01, 16'h0004, 2, 0); endtask

  task automatic test_back_to_back();
    run_frame("hold", 3, 8'h50, 16'h0005, 3, 100);
    run_frame("retrig", 18, 8'h60, 16'h0006, 18, 0);
  endtask

  task automatic test_reset_mid_read();
    int rd0;
    frame_cnt  = 16'h0007;
    frame_type = 4'h7;
    data_count = 16'd40;
    sb.push_back({hdr_sync, frame_type, 4'h0, frame_cnt, src_id, des_id, data_type, data_chan,
                  16'd40, 24'h0});
    for (int i = 0; i < 40; i++) fifo.push_back(8'(i));
    rd0 = rd_cnt;
    tick();
    start = 1'b1;
    for (int i = 0; i < 200 && rd_cnt - rd0 < 8; i++) tick();
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    vectors++;
    if ({flow_valid_o, rd_en_o, send_done_o} !== 3'b000 || flow_data_o !== 128'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got v=%b rd=%b done=%b data=%h, required all 0",
               flow_valid_o, rd_en_o, send_done_o, flow_data_o);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL midreset_header: got %0d header words pending, required 0", sb.size());
    end
    sb.delete();
    fifo.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    rd0 = rd_cnt;
    begin
      int f0, d0;
      f0 = flow_cnt; d0 = done_cnt;
      repeat (20) tick();
      vectors++;
      if (flow_cnt != f0 || rd_cnt != rd0 || done_cnt != d0) begin
        miscompares++;
        $display("FAIL midreset_idle: got words=%0d reads=%0d dones=%0d, required 0/0/0",
                 flow_cnt - f0, rd_cnt - rd0, done_cnt - d0);
      end
    end
    run_frame("recover", 7, 8'hC0, 16'h0008, 7, 0);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_full_word();
    test_partial();
    test_empty_stall();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
